// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment scan block: register map,
// CTRL field layout, scan states and the active-low hex segment table.
package ss_pkg;

   localparam logic [1:0] REG_DIGITS   = 2'd0;
   localparam logic [1:0] REG_CTRL     = 2'd1;
   localparam logic [1:0] REG_PRESCALE = 2'd2;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_BLANK_LSB = 4;
   localparam int CTRL_DP_LSB    = 8;

   typedef enum logic [1:0] {IDLE, GUARD, ON} scan_state_t;

   typedef struct packed {
      logic [3:0] dp;
      logic [3:0] blank;
      logic       en;
   } ctrl_t;

   // Index is the nibble value; bit0 = segment a, 0 = lit.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/ss_hex_decoder.sv
// Registered hex nibble to active-low seven-segment pattern.
// Blank forces all segments dark.
module ss_hex_decoder
   import ss_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_blank,
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg_n
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_seg_n <= 7'h7F;
      end else if (i_blank) begin
         o_seg_n <= 7'h7F;
      end else begin
         o_seg_n <= SEG_LUT[i_nib];
      end
   end

endmodule

// File: rtl/ss_display_scan.sv
// Four-digit common-anode display scanner with staged registers that
// commit only at frame boundaries, programmable slot length and guard.
module ss_display_scan
   import ss_pkg::*;
#(
   parameter int          NUM_DIGITS       = 4,
   parameter int          DATA_WIDTH       = 32,
   parameter logic [15:0] DEFAULT_PRESCALE = 16'd50000,
   parameter int          GUARD_CYCLES     = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  reg_wr_en,
   input  logic [1:0]            reg_wr_idx,
   input  logic [DATA_WIDTH-1:0] reg_wr_data,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic                  frame_tick,
   output logic                  busy
);

   localparam logic [15:0] GUARD_W  = 16'(GUARD_CYCLES);
   localparam logic [1:0]  LAST_DIG = 2'(NUM_DIGITS - 1);

   logic [15:0] r_stg_digits, w_stg_digits_nxt;
   ctrl_t       r_stg_ctrl,   w_stg_ctrl_nxt;
   logic [15:0] r_stg_pre,    w_stg_pre_nxt;

   logic [15:0] r_act_digits, w_act_digits_nxt;
   ctrl_t       r_act_ctrl,   w_act_ctrl_nxt;
   logic [15:0] r_act_pre,    w_act_pre_nxt;

   scan_state_t r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [1:0]  r_dig, w_dig_nxt;

   logic [15:0]           w_len, w_len_nxt;
   logic                  w_commit;
   logic                  w_run_nxt;
   logic [NUM_DIGITS-1:0] w_an_nxt;
   logic                  w_dp_nxt;
   logic                  w_tick_nxt;
   logic [3:0]            w_nib_nxt;
   logic                  w_unused_hi;

   assign w_unused_hi = ^reg_wr_data[DATA_WIDTH-1:16];

   always_comb begin
      w_stg_digits_nxt = r_stg_digits;
      w_stg_ctrl_nxt   = r_stg_ctrl;
      w_stg_pre_nxt    = r_stg_pre;
      if (reg_wr_en) begin
         case (reg_wr_idx)
            REG_DIGITS: begin
               w_stg_digits_nxt = reg_wr_data[15:0];
            end
            REG_CTRL: begin
               w_stg_ctrl_nxt.en    = reg_wr_data[CTRL_EN];
               w_stg_ctrl_nxt.blank = reg_wr_data[CTRL_BLANK_LSB +: 4];
               w_stg_ctrl_nxt.dp    = reg_wr_data[CTRL_DP_LSB +: 4];
            end
            REG_PRESCALE: begin
               w_stg_pre_nxt = reg_wr_data[15:0];
            end
            default: begin
            end
         endcase
      end
   end

   // Commit takes the bypassed staging value so a write in the
   // commit cycle is not lost.
   assign w_commit         = (r_state == IDLE) || frame_tick;
   assign w_act_digits_nxt = w_commit ? w_stg_digits_nxt : r_act_digits;
   assign w_act_ctrl_nxt   = w_commit ? w_stg_ctrl_nxt   : r_act_ctrl;
   assign w_act_pre_nxt    = w_commit ? w_stg_pre_nxt    : r_act_pre;

   assign w_len     = (r_act_pre == 16'd0) ? 16'd1 : r_act_pre;
   assign w_len_nxt = (w_act_pre_nxt == 16'd0) ? 16'd1 : w_act_pre_nxt;
   assign w_cnt_inc = r_cnt + 16'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dig_nxt   = r_dig;
      if (!r_act_ctrl.en) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = 16'd0;
         w_dig_nxt   = 2'd0;
      end else if (r_state == IDLE) begin
         w_state_nxt = GUARD;
         w_cnt_nxt   = 16'd0;
         w_dig_nxt   = 2'd0;
      end else if (r_cnt == w_len - 16'd1) begin
         w_state_nxt = GUARD;
         w_cnt_nxt   = 16'd0;
         w_dig_nxt   = (r_dig == LAST_DIG) ? 2'd0 : r_dig + 2'd1;
      end else begin
         w_cnt_nxt   = w_cnt_inc;
         w_state_nxt = (w_cnt_inc >= GUARD_W) ? ON : GUARD;
      end
   end

   // Outputs are registered from next-cycle values so they line up
   // with the state they describe.
   always_comb begin
      w_run_nxt = (w_state_nxt != IDLE);
      w_an_nxt  = '1;
      if (w_state_nxt == ON && !w_act_ctrl_nxt.blank[w_dig_nxt]) begin
         w_an_nxt[w_dig_nxt] = 1'b0;
      end
      w_dp_nxt   = !(w_run_nxt && w_act_ctrl_nxt.dp[w_dig_nxt]);
      w_tick_nxt = w_run_nxt && (w_dig_nxt == LAST_DIG)
                && (w_cnt_nxt == w_len_nxt - 16'd1);
      w_nib_nxt  = w_act_digits_nxt[{w_dig_nxt, 2'b00} +: 4];
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_stg_digits <= '0;
         r_stg_ctrl   <= '0;
         r_stg_pre    <= DEFAULT_PRESCALE;
         r_act_digits <= '0;
         r_act_ctrl   <= '0;
         r_act_pre    <= DEFAULT_PRESCALE;
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_dig        <= '0;
         an_n         <= '1;
         dp_n         <= 1'b1;
         frame_tick   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         r_stg_digits <= w_stg_digits_nxt;
         r_stg_ctrl   <= w_stg_ctrl_nxt;
         r_stg_pre    <= w_stg_pre_nxt;
         r_act_digits <= w_act_digits_nxt;
         r_act_ctrl   <= w_act_ctrl_nxt;
         r_act_pre    <= w_act_pre_nxt;
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_dig        <= w_dig_nxt;
         an_n         <= w_an_nxt;
         dp_n         <= w_dp_nxt;
         frame_tick   <= w_tick_nxt;
         busy         <= w_run_nxt;
      end
   end

   ss_hex_decoder u_dec (
      .i_clk   (ACLK),
      .i_rst_n (ARESETN),
      .i_blank (!w_run_nxt),
      .i_nib   (w_nib_nxt),
      .o_seg_n (seg_n)
   );

endmodule

// File: doc/ss_display_scan.md
Name: ss_display_scan

Overview:
- Downstream consumer of the SS AXI4-Lite slave register file. Drives a time-multiplexed, common-anode, 4-digit seven-segment display.
- The slave forwards every accepted register write as a one-cycle strobe (index plus data). This block holds the values in staging registers.
- Staged values are committed to the active set only at a frame boundary, so a display frame never tears.
- The block scans the digits with a programmable slot length and an anti-ghosting guard interval.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; fixed at 4 by the register map.
- DATA_WIDTH, 32, width of the write data bus (matches the AXI slave).
- DEFAULT_PRESCALE, 16'd50000, reset value of the slot length in clocks.
- GUARD_CYCLES, 4, clocks at the start of each slot during which all anodes are off.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- reg_wr_en  in  1  one-cycle strobe: the slave accepted a write.
- reg_wr_idx  in  2  register index of that write: 0 DIGITS, 1 CTRL, 2 PRESCALE, 3 reserved.
- reg_wr_data  in  DATA_WIDTH  write data (full word, already strobe-merged by the slave).
- seg_n  out  7  segments a..g, active-low; bit0 = a.
- dp_n  out  1  decimal point, active-low.
- an_n  out  NUM_DIGITS  anode enables, active-low.
- frame_tick  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1.
- busy  out  1  high while the scan is running (state != IDLE).

Behaviour:

Register map (staging):
- DIGITS[15:0]: nibble i is the hex value of digit i.
- CTRL bit0: enable.
- CTRL[7:4]: blank mask (1 = digit dark).
- CTRL[11:8]: dp mask (1 = dp lit).
- PRESCALE[15:0]: slot length in clocks.
- Index 3 writes are ignored. Upper unused bits are ignored.

Reset (ARESETN low, asynchronous):
- an_n = all 1, seg_n = 7'h7F, dp_n = 1, frame_tick = 0, busy = 0.
- Staging and active DIGITS = 0 and CTRL = 0.
- Staging and active PRESCALE = DEFAULT_PRESCALE.
- State = IDLE; slot counter = 0; digit index = 0.
- Deassertion is used directly; no reset synchroniser in this block.

Effective slot length: L = max(active PRESCALE, 1).

Commit (staging -> active, all three registers at once):
- Occurs on a frame_tick cycle, or on every cycle while state = IDLE.
- A write in the commit cycle is bypassed, so the committed value includes it.

State machine:
- IDLE:
  - All anodes off.
  - Goes to GUARD with digit 0 and slot counter 0 when the active CTRL.enable is 1.
- GUARD:
  - seg_n and dp_n already present the decode of the current digit; anodes off.
  - Goes to ON when slot counter = GUARD_CYCLES-1.
  - If L <= GUARD_CYCLES, it stays in GUARD for the whole slot and the digit never lights.
- ON:
  - an_n[digit] = 0, unless that digit's blank bit is set, in which case all anodes stay off.
- Slot counter:
  - Increments each cycle in GUARD and ON.
  - At L-1 it wraps to 0 and the digit index advances (wrapping NUM_DIGITS-1 -> 0); the next state is GUARD.
- frame_tick is asserted when slot counter = L-1 and digit = NUM_DIGITS-1.
- Enable 0 in the active CTRL: the next clock forces IDLE (mid-slot is allowed). Anodes go off, and the counter and index are cleared.
- Disable takes effect at the next commit: the frame boundary when running, or immediately when IDLE.

Outputs:
- All outputs are registered; no combinational input-to-output paths.
- seg_n uses the hex decode 0-F: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- seg_n and dp_n are 7'h7F / 1 in IDLE.

Latency:
- Write -> active: the next commit.
- Anodes light GUARD_CYCLES clocks after slot start.
- From IDLE with enable written at cycle t: active at t+1, GUARD entered at t+2.

Decomposition:
- ss_pkg holds:
  - localparams REG_DIGITS=0, REG_CTRL=1, REG_PRESCALE=2;
  - CTRL bit positions;
  - typedef enum logic [1:0] {IDLE, GUARD, ON} scan_state_t;
  - the 16-entry seg_lut constant.
- One sub-module, ss_hex_decoder (registered 4-bit -> 7-bit, active-low), instantiated once.

Test Plan:
1. Reset check: hold ARESETN low mid-scan -> all outputs return to reset values immediately (asynchronous), busy=0.
2. Basic scan (GUARD_CYCLES=4):
   - Stimulus: write PRESCALE=10, DIGITS=16'h3210, CTRL=1.
   - Expect: each digit slot is 10 clocks, the anode is low for cycles 4-9, and the digits are scanned in order 0,1,2,3.
   - Expect seg_n values 7'h40, 7'h79, 7'h24, 7'h30.
   - Expect frame_tick every 40 clocks.
3. Tear-free update: while running, write DIGITS=16'hFEDC at digit 1, slot counter 3 -> digits 1-3 of the current frame still show 1,2,3; the next frame shows C,D,E,F.
4. Blank and dp: CTRL=16'h0A51 (enable, blank digits 0 and 2, dp digits 1 and 3):
   - Anodes 0 and 2 never go low.
   - dp_n=0 during digits 1 and 3 only.
5. Edge slot lengths:
   - PRESCALE=0 -> treated as L=1, and an_n stays all 1.
   - PRESCALE=4 -> an_n stays all 1, frame_tick every 16 clocks.
   - PRESCALE=5 -> each anode is low exactly 1 cycle per slot.
6. Disable and reserved writes:
   - Write CTRL=0 at digit 2 -> the scan continues to frame_tick, then goes to IDLE; busy=0 and an_n=4'hF.
   - A write to index 3 changes nothing.
